wb_uart_master: RTL
===================

// Module: wb_uart_master
// PURPOSE
//   Debug bridge: UART byte-stream command protocol -> Wishbone master. Host sends framed
//   read/write commands over serial; block issues single 32-bit Wishbone classic cycles on
//   the system bus and returns results over serial. Bus-side counterpart of wb_uart.
//   Instantiates the shared uart core (freq_hz/baud) for the serial PHY.
// PARAMETERS
//   clk_freq  100000000  system clock in Hz, passed to uart.freq_hz
//   baud      115200     serial bit rate, passed to uart.baud
//   timeout   1024       bus-ack timeout in clk cycles (used only with WB_UART_MASTER_TIMEOUT_EN)
// PORTS
//   clk       in   1   system clock, all logic on rising edge
//   reset     in   1   synchronous, active-high reset
//   uart_rxd  in   1   serial input
//   uart_txd  out  1   serial output
//   wb_cyc_o  out  1   bus cycle
//   wb_stb_o  out  1   strobe, identical to wb_cyc_o
//   wb_we_o   out  1   1 = write cycle
//   wb_adr_o  out  32  byte address, as received
//   wb_sel_o  out  4   byte select, constant 4'hF
//   wb_dat_o  out  32  write data
//   wb_dat_i  in   32  read data, sampled on ack
//   wb_ack_i  in   1   cycle acknowledge
//   busy      out  1   1 whenever FSM is not IDLE
// BEHAVIOUR
// - Frame: CMD byte, ADDR[31:24..7:0] (4 bytes MSB first), write only: DATA 4 bytes MSB first.
//   CMD 0x57 'W' = write, 0x52 'R' = read. Any other CMD byte consumed and dropped, stay IDLE.
// - Replies: write -> 0x4B 'K'; read -> 4 data bytes MSB first.
// - Reset: wb_cyc_o/stb/we=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=4'hF, busy=0, rx_ack=0,
//   tx_wr=0, FSM=IDLE, byte counters 0. Reset mid-frame or mid-bus-cycle discards everything.
// - RX consume: byte taken when rx_avail=1 and rx_ack was 0 the previous cycle; rx_ack pulses
//   1 cycle in the same cycle the byte is registered (no double-consume of a byte).
// - rx_error=1 in any state before BUS: pulse rx_ack, discard partial frame, -> IDLE, no reply.
//   rx_error in BUS/RESP ignored (clearing deferred to next IDLE consume).
// - States: IDLE -> ADDR (cnt 0..3) -> [DATA (cnt 0..3) if write] -> BUS -> RESP -> IDLE.
//   Address/data shift in left by 8 per byte; counter wraps 3->0 on state change.
// - BUS: wb_cyc_o=wb_stb_o=1 on the cycle after the last frame byte is consumed; wb_we_o set
//   with it; adr/dat stable for whole cycle. On the rising edge with wb_ack_i=1: cyc/stb/we
//   drop to 0 on that edge, wb_dat_i latched (read), -> RESP. Minimum bus cycle 1 clock.
// - RESP: send 1 byte (write) or 4 bytes (read). tx_wr pulses 1 cycle when tx_busy=0; after
//   each pulse wait 1 cycle before re-sampling tx_busy (covers uart busy-assert latency).
//   After last byte issued -> IDLE (does not wait for shift-out completion).
// - RX bytes arriving during BUS/RESP remain in uart buffer; consumed after return to IDLE.
// - busy = (state != IDLE), registered.
// CONFIGURATION
//   WB_UART_MASTER_TIMEOUT_EN defined: 32-bit counter cleared on BUS entry, increments each
//     BUS cycle; reaching timeout with no ack -> cyc/stb/we drop, reply single byte 0x54 'T'
//     (both read and write, replaces normal reply), -> IDLE. Ack on the terminal cycle wins.
//   Not defined: no counter; BUS waits indefinitely for wb_ack_i.
// TESTING
// - Write: rx 57 10 00 00 04 DE AD BE EF -> one cycle we=1 adr=0x10000004 dat=0xDEADBEEF
//   sel=F; slave acks after 3 clks -> cyc low same edge; tx 0x4B.
// - Read: rx 52 00 00 00 08, slave returns 0x12345678 with 0-wait ack -> we=0 adr=0x00000008;
//   tx 12 34 56 78 in order; busy returns 0.
// - Junk/framing: rx 0xA5 then 52 00 00 00 00 -> 0xA5 dropped, read proceeds normally;
//   inject rx_error after 2 addr bytes -> no bus cycle, no reply, next frame works.
// - Reset mid-cycle: assert reset while wb_cyc_o=1 -> next clock cyc/stb/we=0, busy=0,
//   no tx byte; subsequent frame executes correctly.
// - Back-to-back: two write frames sent with no gap -> two bus cycles, two 'K' replies,
//   second frame bytes not lost while first is in BUS/RESP.
// - TIMEOUT_EN, timeout=16: read with slave never acking -> cyc low after 16 BUS cycles,
//   tx 0x54 only; ack on cycle 16 -> normal 4-byte reply.

Source files
------------

// File: rtl/wb_uart_master.sv
// UART command bridge to a Wishbone classic master: 'W'/'R' frames in, 'K' or read data out.
// Define WB_UART_MASTER_TIMEOUT_EN to abort unacknowledged bus cycles with a 'T' reply.
module wb_uart_master #(
  parameter int clk_freq = 100000000,
  parameter int baud     = 115200,
  parameter int timeout  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t      state_q, state_n;
  logic [1:0]  cnt_q, cnt_n;
  logic        is_wr_q, is_wr_n;
  logic [31:0] adr_q, adr_n, dat_q, dat_n, resp_q, resp_n;
  logic        rx_ack_q, rx_ack_n, tx_wr_q, tx_wr_n;
  logic        wait_q, wait_n, short_q, short_n;
  logic        cyc_q, cyc_n, we_q, we_n, busy_q;
  logic [7:0]  rx_data;
  logic        rx_avail, rx_error, tx_busy, take;
`ifdef WB_UART_MASTER_TIMEOUT_EN
  logic [31:0] to_q, to_n;
`endif

  uart #(.freq_hz(clk_freq), .baud(baud)) u_uart (
    .clk      (clk),
    .reset    (reset),
    .rxd      (uart_rxd),
    .txd      (uart_txd),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_error (rx_error),
    .rx_ack   (rx_ack_q),
    .tx_data  (resp_q[31:24]),
    .tx_wr    (tx_wr_q),
    .tx_busy  (tx_busy)
  );

  // A byte (or error) is taken only if it was not acknowledged last cycle.
  assign take = (rx_avail | rx_error) & ~rx_ack_q;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    is_wr_n  = is_wr_q;
    adr_n    = adr_q;
    dat_n    = dat_q;
    resp_n   = resp_q;
    short_n  = short_q;
    rx_ack_n = 1'b0;
    tx_wr_n  = 1'b0;
    wait_n   = 1'b0;
`ifdef WB_UART_MASTER_TIMEOUT_EN
    to_n     = '0;
`endif
    case (state_q)
      S_IDLE: if (take) begin
        rx_ack_n = 1'b1;
        cnt_n    = 2'd0;
        if (!rx_error && (rx_data == 8'h57 || rx_data == 8'h52)) begin
          is_wr_n = (rx_data == 8'h57);
          state_n = S_ADDR;
        end
      end
      S_ADDR: if (take) begin
        rx_ack_n = 1'b1;
        if (rx_error) begin
          state_n = S_IDLE;
          cnt_n   = 2'd0;
        end else begin
          adr_n = {adr_q[23:0], rx_data};
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_n = is_wr_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: if (take) begin
        rx_ack_n = 1'b1;
        if (rx_error) begin
          state_n = S_IDLE;
          cnt_n   = 2'd0;
        end else begin
          dat_n = {dat_q[23:0], rx_data};
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_n = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          state_n = S_RESP;
          cnt_n   = 2'd0;
          short_n = is_wr_q;
          resp_n  = is_wr_q ? {8'h4B, 24'h0} : wb_dat_i;
        end
`ifdef WB_UART_MASTER_TIMEOUT_EN
        else if (to_q == 32'(timeout - 1)) begin
          state_n = S_RESP;
          cnt_n   = 2'd0;
          short_n = 1'b1;
          resp_n  = {8'h54, 24'h0};
        end else begin
          to_n = to_q + 32'd1;
        end
`endif
      end
      S_RESP: begin
        // The cycle after a write strobe is skipped so tx_busy has time to rise.
        if (tx_wr_q) begin
          wait_n = 1'b1;
          resp_n = {resp_q[23:0], 8'h00};
          cnt_n  = cnt_q + 2'd1;
          if (short_q || cnt_q == 2'd3) begin
            state_n = S_IDLE;
            cnt_n   = 2'd0;
          end
        end else if (!wait_q && !tx_busy) begin
          tx_wr_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    cyc_n = (state_n == S_BUS);
    we_n  = cyc_n & is_wr_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      is_wr_q  <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      resp_q   <= '0;
      short_q  <= 1'b0;
      rx_ack_q <= 1'b0;
      tx_wr_q  <= 1'b0;
      wait_q   <= 1'b0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef WB_UART_MASTER_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      is_wr_q  <= is_wr_n;
      adr_q    <= adr_n;
      dat_q    <= dat_n;
      resp_q   <= resp_n;
      short_q  <= short_n;
      rx_ack_q <= rx_ack_n;
      tx_wr_q  <= tx_wr_n;
      wait_q   <= wait_n;
      cyc_q    <= cyc_n;
      we_q     <= we_n;
      busy_q   <= (state_n != S_IDLE);
`ifdef WB_UART_MASTER_TIMEOUT_EN
      to_q     <= to_n;
`endif
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign busy     = busy_q;
endmodule

// Minimal 8N1 uart core: one-byte receive holding register, rx_ack clears avail/error.
module uart #(
  parameter int freq_hz = 100000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);
  localparam int CPB = freq_hz / baud;
  localparam int TW  = $clog2(CPB);
  localparam logic [TW-1:0] FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF = TW'(CPB / 2 - 1);

  logic          rx_meta, rx_s, rx_prev, rx_on;
  logic [3:0]    rx_bit, tx_bit;
  logic [TW-1:0] rx_tmr, tx_tmr;
  logic [7:0]    rx_sh;
  logic [9:0]    tx_sh;

  // Receiver restarts only on a falling edge, so a low stop bit cannot retrigger it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_on    <= 1'b0;
      rx_bit   <= 4'd0;
      rx_tmr   <= '0;
      rx_sh    <= 8'h00;
      rx_data  <= 8'h00;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (rx_ack) begin
        rx_avail <= 1'b0;
        rx_error <= 1'b0;
      end
      if (!rx_on) begin
        if (rx_prev && !rx_s) begin
          rx_on  <= 1'b1;
          rx_bit <= 4'd0;
          rx_tmr <= HALF;
        end
      end else if (rx_tmr != '0) begin
        rx_tmr <= rx_tmr - 1'b1;
      end else begin
        rx_tmr <= FULL;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_on <= 1'b0;
        end else if (rx_bit <= 4'd8) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
        end else begin
          rx_on <= 1'b0;
          if (rx_s) begin
            rx_data  <= rx_sh;
            rx_avail <= 1'b1;
          end else begin
            rx_error <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_bit  <= 4'd0;
      tx_tmr  <= '0;
    end else if (!tx_busy) begin
      if (tx_wr) begin
        tx_sh   <= {1'b1, tx_data, 1'b0};
        tx_busy <= 1'b1;
        tx_bit  <= 4'd0;
        tx_tmr  <= FULL;
      end
    end else if (tx_tmr != '0) begin
      tx_tmr <= tx_tmr - 1'b1;
    end else begin
      tx_tmr <= FULL;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_sh  <= {1'b1, tx_sh[9:1]};
        tx_bit <= tx_bit + 4'd1;
      end
    end
  end

  assign txd = tx_busy ? tx_sh[0] : 1'b1;
endmodule
